// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Decode-side hazard unit. A shift-register tag pipe records the in-flight
// register writers; each source operand picks the youngest matching producer
// to forward from. Load-use hazards stall decode through a small counting FSM,
// and every stall cycle is tallied in a saturating performance counter.
module hazard_forward_unit #(
    parameter int  REG_ADDR_W = 4,
    parameter int  NUM_SRC    = 2,
    parameter int  FWD_DEPTH  = 3,
    parameter int  LOAD_LAT   = 1,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic [15:0]                   perf_stall_cnt
);

    localparam int TAG_W = REG_ADDR_W + 3;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  ld;
    } tag_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    tag_t               tag_r [1:FWD_DEPTH];
    tag_t               tag_in_s;
    state_t             state_r;
    state_t             state_nxt_s;
    logic [SEL_W-1:0]   cnt_r;
    logic [SEL_W-1:0]   cnt_nxt_s;
    logic [15:0]        perf_r;
    logic [FWD_DEPTH:1] match_s [NUM_SRC];
    logic [FWD_DEPTH:1] any_match_s;
    logic [SEL_W-1:0]   youngest_s [NUM_SRC];
    logic               hazard_s;
    logic [SEL_W-1:0]   kh_s;
    logic [SEL_W-1:0]   load_wait_s;
    logic               stall_s;

    // Compare every source operand against every tracked producer; youngest match wins
    always_comb begin
        any_match_s = {FWD_DEPTH{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            match_s[i]    = {FWD_DEPTH{1'b0}};
            youngest_s[i] = {SEL_W{1'b0}};
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                match_s[i][k] = tag_r[k].vld & tag_r[k].wr & id_rs_used[i]
                              & (tag_r[k].rd == id_rs[i*REG_ADDR_W +: REG_ADDR_W])
                              & (id_rs[i*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}});
                youngest_s[i] = match_s[i][k] ? SEL_W'(k) : youngest_s[i];
            end
            any_match_s = any_match_s | match_s[i];
        end
    end

    // Youngest load producer whose data is not yet forwardable
    always_comb begin
        hazard_s = 1'b0;
        kh_s     = {SEL_W{1'b0}};
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            hazard_s = hazard_s | (any_match_s[k] & tag_r[k].ld & (k <= LOAD_LAT));
            kh_s     = (any_match_s[k] && tag_r[k].ld && (k <= LOAD_LAT)) ? SEL_W'(k) : kh_s;
        end
        load_wait_s = SEL_W'(LOAD_LAT) - kh_s;
    end

    // Load-use stall control: stall request, next state and remaining stall count
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                stall_s = hazard_s & id_valid & ~flush;
                if (stall_s && (load_wait_s != {SEL_W{1'b0}})) begin
                    state_nxt_s = ST_STALL;
                    cnt_nxt_s   = load_wait_s;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_STALL: begin
                stall_s   = ~flush;
                cnt_nxt_s = cnt_r - SEL_W'(1'b1);
                if (cnt_r == SEL_W'(1'b1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = {SEL_W{1'b0}};
            end
        endcase
        // A redirect abandons any pending load-use wait
        state_nxt_s = flush ? ST_RUN : state_nxt_s;
        cnt_nxt_s   = flush ? {SEL_W{1'b0}} : cnt_nxt_s;
    end

    // Entry offered to tag stage 1; squashed while flushing or stalling
    always_comb begin
        if (flush || stall_s) begin
            tag_in_s = {TAG_W{1'b0}};
        end else begin
            tag_in_s = {id_valid, id_rd, id_regwrite & (id_rd != {REG_ADDR_W{1'b0}}), id_memread};
        end
    end

    // Tag pipe: stage 1 captures the decode slot, older stages shift down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                tag_r[k] <= {TAG_W{1'b0}};
            end
        end else begin
            tag_r[1] <= tag_in_s;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Stall FSM state and remaining-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= {SEL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 16'h0000;
        end else if (stall_s && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'h0001;
        end else begin
            perf_r <= perf_r;
        end
    end

    // Forward selects are suppressed while stalling or for an empty decode slot
    always_comb begin
        fwd_sel = {(NUM_SRC*SEL_W){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i*SEL_W +: SEL_W] = (stall_s || !id_valid) ? {SEL_W{1'b0}} : youngest_s[i];
        end
    end

    assign stall          = stall_s;
    assign bubble         = stall_s & ~flush;
    assign perf_stall_cnt = perf_r;

endmodule
